// File: rtl/sci_frame_gate.sv
// rtl/sci_frame_gate.sv - SCI receive frame gate with one-word hold buffer, sof/eof marking,
// length policing and per-frame status counters.
module sci_frame_gate #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 256,
    parameter int MIN_LEN = 1,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              k,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              sof,
    output logic              eof,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [LEN_W-1:0]  frame_len,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               k_q;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               first_q, first_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic [1:0]         code_q, code_d;
    logic [LEN_W-1:0]   flen_q, flen_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;

    logic q, fall, rise;

    assign q    = valid_in && !k;
    assign fall = !k && k_q;
    assign rise = k && !k_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = first_q;
        len_d       = len_q;
        valid_d     = 1'b0;
        dout_d      = dout_q;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        done_d      = 1'b0;
        ferr_d      = 1'b0;
        code_d      = 2'b00;
        flen_d      = flen_q;
        fcnt_d      = fcnt_q;
        ecnt_d      = ecnt_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = DATA;
                    first_d     = 1'b1;
                    len_d       = '0;
                    hold_full_d = 1'b0;
                    if (q) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                        len_d       = LEN_W'(1);
                    end
                end
            end
            DATA: begin
                if (q) begin
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        // Frame is full: close it out early with eof, then swallow the rest.
                        state_d     = DROP;
                        valid_d     = hold_full_q;
                        dout_d      = hold_q;
                        sof_d       = first_q;
                        eof_d       = hold_full_q;
                        hold_full_d = 1'b0;
                        first_d     = 1'b0;
                    end else begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                        len_d       = len_q + LEN_W'(1);
                        if (hold_full_q) begin
                            valid_d = 1'b1;
                            dout_d  = hold_q;
                            sof_d   = first_q;
                            first_d = 1'b0;
                        end
                    end
                end else if (rise) begin
                    state_d     = IDLE;
                    hold_full_d = 1'b0;
                    if (hold_full_q) begin
                        valid_d = 1'b1;
                        dout_d  = hold_q;
                        sof_d   = first_q;
                        eof_d   = 1'b1;
                    end
                    done_d = 1'b1;
                    flen_d = len_q;
                    if ((MIN_LEN > 0) && (32'(len_q) < 32'(MIN_LEN))) begin
                        ferr_d = 1'b1;
                        code_d = 2'b01;
                    end
                end
            end
            DROP: begin
                if (rise) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ferr_d  = 1'b1;
                    code_d  = 2'b10;
                    flen_d  = LEN_W'(MAX_LEN);
                end
            end
            default: state_d = IDLE;
        endcase

        if (done_d) begin
            fcnt_d = fcnt_q + CNT_W'(1);
            if (ferr_d && (ecnt_q != {CNT_W{1'b1}})) begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            len_q       <= '0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            code_q      <= 2'b00;
            flen_q      <= '0;
            fcnt_q      <= '0;
            ecnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            len_q       <= len_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            code_q      <= code_d;
            flen_q      <= flen_d;
            fcnt_q      <= fcnt_d;
            ecnt_q      <= ecnt_d;
        end
    end

    assign valid      = valid_q;
    assign dout       = dout_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;
    assign err_code   = code_q;
    assign frame_len  = flen_q;
    assign frame_cnt  = fcnt_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_sci_frame_gate.sv
// tb/tb_sci_frame_gate.sv - bench for sci_frame_gate: default instance plus a small
// MAX_LEN=4/MIN_LEN=2/CNT_W=2 instance, table vectors, corner sequences and random traffic.
module tb_sci_frame_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       k = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] din = 8'h00;

    logic       a_valid, a_sof, a_eof, a_done, a_ferr;
    logic [7:0] a_dout;
    logic [1:0] a_code;
    logic [8:0] a_len;
    logic [15:0] a_fcnt, a_ecnt;

    logic       b_valid, b_sof, b_eof, b_done, b_ferr;
    logic [7:0] b_dout;
    logic [1:0] b_code;
    logic [2:0] b_len;
    logic [1:0] b_fcnt, b_ecnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sci_frame_gate dut_a (
        .clk(clk), .rst(rst), .k(k), .valid_in(valid_in), .din(din),
        .valid(a_valid), .dout(a_dout), .sof(a_sof), .eof(a_eof),
        .frame_done(a_done), .frame_err(a_ferr), .err_code(a_code),
        .frame_len(a_len), .frame_cnt(a_fcnt), .err_cnt(a_ecnt)
    );

    sci_frame_gate #(.DATA_W(8), .MAX_LEN(4), .MIN_LEN(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .k(k), .valid_in(valid_in), .din(din),
        .valid(b_valid), .dout(b_dout), .sof(b_sof), .eof(b_eof),
        .frame_done(b_done), .frame_err(b_ferr), .err_code(b_code),
        .frame_len(b_len), .frame_cnt(b_fcnt), .err_cnt(b_ecnt)
    );

    typedef struct {
        bit         valid;
        logic [7:0] dout;
        bit         sof;
        bit         eof;
        bit         done;
        bit         ferr;
        logic [1:0] code;
        int         len;
        int         fcnt;
        int         ecnt;
    } exp_t;

    exp_t       ex [2];
    bit         inf [2];
    bit         drp [2];
    bit         pk [2];
    logic [7:0] wq0 [$];
    logic [7:0] wq1 [$];
    logic [7:0] b_seen [$];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ex[m] = '{0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0};
            inf[m] = 0;
            drp[m] = 0;
            pk[m] = 0;
        end
        wq0.delete();
        wq1.delete();
    endtask

    // Frame-level reference: the accepted words of the current frame live in a queue,
    // and word i becomes visible once word i+1 arrives or the frame ends.
    task automatic model_step(input int m, input bit kk, input bit vv, input logic [7:0] dd);
        int maxl, minl, cmax, n;
        logic [7:0] w [$];
        exp_t e;
        bit qq, fall, rise, fin;
        maxl = (m == 0) ? 256 : 4;
        minl = (m == 0) ? 1 : 2;
        cmax = (m == 0) ? 65535 : 3;
        if (m == 0) w = wq0; else w = wq1;
        e = ex[m];
        e.valid = 0; e.sof = 0; e.eof = 0; e.done = 0; e.ferr = 0; e.code = 2'b00;
        fin = 0;
        qq = vv && !kk;
        fall = !kk && pk[m];
        rise = kk && !pk[m];
        if (!inf[m]) begin
            if (fall) begin
                inf[m] = 1;
                drp[m] = 0;
                w.delete();
                if (qq) w.push_back(dd);
            end
        end else if (drp[m]) begin
            if (rise) begin
                inf[m] = 0;
                e.done = 1; e.ferr = 1; e.code = 2'b10; e.len = maxl;
                fin = 1;
            end
        end else if (qq) begin
            if (w.size() < maxl) begin
                w.push_back(dd);
                n = w.size();
                if (n >= 2) begin
                    e.valid = 1; e.dout = w[n-2]; e.sof = (n == 2);
                end
            end else begin
                e.valid = 1; e.dout = w[maxl-1]; e.sof = (maxl == 1); e.eof = 1;
                drp[m] = 1;
            end
        end else if (rise) begin
            n = w.size();
            if (n > 0) begin
                e.valid = 1; e.dout = w[n-1]; e.sof = (n == 1); e.eof = 1;
            end
            e.done = 1; e.len = n;
            if (minl > 0 && n < minl) begin
                e.ferr = 1; e.code = 2'b01;
            end
            inf[m] = 0;
            fin = 1;
        end
        if (fin) begin
            e.fcnt = (e.fcnt + 1) % (cmax + 1);
            if (e.ferr && e.ecnt < cmax) e.ecnt++;
        end
        pk[m] = kk;
        ex[m] = e;
        if (m == 0) wq0 = w; else wq1 = w;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic cmp_model();
        exp_t e;
        bit ok;
        e = ex[0];
        ok = (a_valid == e.valid) && (a_sof == e.sof) && (a_eof == e.eof) &&
             (a_done == e.done) && (a_ferr == e.ferr) && (a_code == e.code) &&
             (!e.valid || a_dout == e.dout) && (!e.done || int'(a_len) == e.len) &&
             (int'(a_fcnt) == e.fcnt) && (int'(a_ecnt) == e.ecnt);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL model_a cycle %0d: got v%0d d%02h s%0d e%0d done%0d err%0d c%0d len%0d fc%0d ec%0d expected v%0d d%02h s%0d e%0d done%0d err%0d c%0d len%0d fc%0d ec%0d",
                     cyc, a_valid, a_dout, a_sof, a_eof, a_done, a_ferr, a_code, a_len, a_fcnt, a_ecnt,
                     e.valid, e.dout, e.sof, e.eof, e.done, e.ferr, e.code, e.len, e.fcnt, e.ecnt);
        end
        e = ex[1];
        ok = (b_valid == e.valid) && (b_sof == e.sof) && (b_eof == e.eof) &&
             (b_done == e.done) && (b_ferr == e.ferr) && (b_code == e.code) &&
             (!e.valid || b_dout == e.dout) && (!e.done || int'(b_len) == e.len) &&
             (int'(b_fcnt) == e.fcnt) && (int'(b_ecnt) == e.ecnt);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL model_b cycle %0d: got v%0d d%02h s%0d e%0d done%0d err%0d c%0d len%0d fc%0d ec%0d expected v%0d d%02h s%0d e%0d done%0d err%0d c%0d len%0d fc%0d ec%0d",
                     cyc, b_valid, b_dout, b_sof, b_eof, b_done, b_ferr, b_code, b_len, b_fcnt, b_ecnt,
                     e.valid, e.dout, e.sof, e.eof, e.done, e.ferr, e.code, e.len, e.fcnt, e.ecnt);
        end
    endtask

    // Called at #1 after a rising edge; drives one input cycle and checks its outputs.
    task automatic apply(input bit kk, input bit vv, input logic [7:0] dd);
        k = kk;
        valid_in = vv;
        din = dd;
        model_step(0, kk, vv, dd);
        model_step(1, kk, vv, dd);
        @(posedge clk);
        #1;
        cyc++;
        if (b_valid) b_seen.push_back(b_dout);
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_a_pulses", {a_valid, a_sof, a_eof, a_done, a_ferr, a_code}, 0);
        chk("rst_a_dout_len", {a_dout, a_len}, 0);
        chk("rst_a_counters", {a_fcnt, a_ecnt}, 0);
        chk("rst_b_all", {b_valid, b_sof, b_eof, b_done, b_ferr, b_code, b_dout, b_len, b_fcnt, b_ecnt}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         k;
        bit         v;
        logic [7:0] d;
        bit         ev;
        logic [7:0] edout;
        bit         es;
        bit         ee;
        bit         ed;
        logic [1:0] ecode;
        int         elen;
        int         efcnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int vc, pflip;
        bit ok;
        tbl[0]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00, 0, 0};
        tbl[1]  = '{0, 1, 8'h11, 0, 8'h00, 0, 0, 0, 2'b00, 0, 0};
        tbl[2]  = '{0, 1, 8'h22, 1, 8'h11, 1, 0, 0, 2'b00, 0, 0};
        tbl[3]  = '{0, 1, 8'h33, 1, 8'h22, 0, 0, 0, 2'b00, 0, 0};
        tbl[4]  = '{0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00, 0, 0};
        tbl[5]  = '{1, 1, 8'hff, 1, 8'h33, 0, 1, 1, 2'b00, 3, 1};
        tbl[6]  = '{1, 1, 8'hee, 0, 8'h00, 0, 0, 0, 2'b00, 0, 1};
        tbl[7]  = '{0, 1, 8'ha5, 0, 8'h00, 0, 0, 0, 2'b00, 0, 1};
        tbl[8]  = '{1, 0, 8'h00, 1, 8'ha5, 1, 1, 1, 2'b00, 1, 2};
        tbl[9]  = '{0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00, 0, 2};
        tbl[10] = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 2'b01, 0, 3};
        tbl[11] = '{1, 1, 8'h55, 0, 8'h00, 0, 0, 0, 2'b00, 0, 3};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].k, tbl[i].v, tbl[i].d);
            ok = (a_valid == tbl[i].ev) && (a_sof == tbl[i].es) && (a_eof == tbl[i].ee) &&
                 (a_done == tbl[i].ed) && (a_code == tbl[i].ecode) &&
                 (a_ferr == (tbl[i].ecode != 2'b00)) &&
                 (!tbl[i].ev || a_dout == tbl[i].edout) &&
                 (!tbl[i].ed || int'(a_len) == tbl[i].elen) && (int'(a_fcnt) == tbl[i].efcnt);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL table row %0d: got v%0d d%02h s%0d e%0d done%0d c%0d len%0d fc%0d expected v%0d d%02h s%0d e%0d done%0d c%0d len%0d fc%0d",
                         i, a_valid, a_dout, a_sof, a_eof, a_done, a_code, a_len, a_fcnt,
                         tbl[i].ev, tbl[i].edout, tbl[i].es, tbl[i].ee, tbl[i].ed,
                         tbl[i].ecode, tbl[i].elen, tbl[i].efcnt);
            end
            if (i == 8) begin
                chk("b_single_short_code", b_code, 1);
                chk("b_single_short_errcnt", b_ecnt, 1);
            end
        end

        // Overflow on the MAX_LEN=4 instance
        do_reset();
        b_seen.delete();
        apply(1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) apply(0, 1, 8'(i));
        apply(0, 1, 8'd5);
        chk("ovf_eof_word", {b_valid, b_eof, b_dout}, {1'b1, 1'b1, 8'd4});
        apply(0, 1, 8'd6);
        chk("ovf_drop_quiet", b_valid, 0);
        apply(1, 0, 8'h00);
        chk("ovf_done_code", {b_done, b_ferr, b_code}, {1'b1, 1'b1, 2'b10});
        chk("ovf_len", b_len, 4);
        chk("ovf_word_count", b_seen.size(), 4);
        chk("ovf_a_normal", {a_done, a_code, a_len}, {1'b1, 2'b00, 9'd6});

        // Empty frames: short errors, B err_cnt saturates and frame_cnt wraps
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 8'h00);
            apply(1, 0, 8'h00);
            chk("empty_done_short", {a_done, a_code, a_valid}, {1'b1, 2'b01, 1'b0});
        end
        chk("sat_b_errcnt", b_ecnt, 3);
        chk("wrap_b_framecnt", b_fcnt, 1);
        chk("a_framecnt", a_fcnt, 5);
        chk("a_errcnt", a_ecnt, 4);

        // Idle control characters with valid_in high
        vc = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 8'(8'h80 + i));
            vc += a_valid + a_done;
        end
        chk("idle_k_quiet", vc, 0);

        // Reset mid-frame, then data with k low must wait for a fresh fall
        apply(0, 1, 8'h10);
        apply(0, 1, 8'h20);
        do_reset();
        vc = 0;
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 8'(8'h40 + i));
            vc += a_valid + a_done + b_valid + b_done;
        end
        chk("post_reset_ignored", vc, 0);
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h77);
        apply(1, 0, 8'h00);
        chk("post_reset_frame", {a_valid, a_sof, a_eof, a_dout, a_fcnt}, {1'b1, 1'b1, 1'b1, 8'h77, 16'd1});

        // Random traffic: short frames first, then long ones to reach the 256-word limit
        for (int i = 0; i < 4500; i++) begin
            pflip = (i < 1500) ? 20 : 350;
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, pflip - 1) == 0) k = ~k;
            apply(k, ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
